led_blink_driver: RTL

- Output-side counterpart to the button pulse path. It turns single-cycle event pulses, such as a keypress pulse or a game event, into human-visible LED blinks on the board.
- Each accepted pulse produces exactly one blink: LED on for ON_CYCLES, then off for OFF_CYCLES.
- Pulses that arrive while a blink is running are queued in a saturating counter and played back-to-back.
- Sits between control logic and the LEDR pins, on the vga_clock domain.

---
 rtl/led_blink_driver.sv | 111 +++++++++++
 1 files changed

// File: rtl/led_blink_driver.sv
// Turns single-cycle event pulses into visible LED blinks (ON_CYCLES on, OFF_CYCLES dark),
// queueing requests that arrive mid-blink in a saturating pending counter.
module led_blink_driver #(
    parameter int unsigned ON_CYCLES   = 6250000,
    parameter int unsigned OFF_CYCLES  = 6250000,
    parameter int unsigned MAX_PENDING = 15,
    parameter int unsigned PEND_W      = $clog2(MAX_PENDING + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pulse,
    output logic              led,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MAX_CYC = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    // Keep at least one bit so 1-cycle phases still synthesize.
    localparam int unsigned TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  PEND_MAX = PEND_W'(MAX_PENDING);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOn   = 2'd1,
        StOff  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               ovf_d;
    logic               led_q, busy_q, ovf_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        pend_d  = pend_q;
        ovf_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pulse) begin
                    state_d = StOn;
                    timer_d = ON_LOAD;
                end
            end
            StOn, StOff: begin
                if (state_q == StOff && timer_q == '0) begin
                    // End of the dark gap: start the next blink if anything is waiting.
                    if (pend_q != '0) begin
                        state_d = StOn;
                        timer_d = ON_LOAD;
                        if (!pulse) begin
                            pend_d = pend_q - PEND_W'(1);
                        end
                    end else if (pulse) begin
                        state_d = StOn;
                        timer_d = ON_LOAD;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    if (state_q == StOn && timer_q == '0) begin
                        state_d = StOff;
                        timer_d = OFF_LOAD;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                    if (pulse) begin
                        if (pend_q < PEND_MAX) begin
                            pend_d = pend_q + PEND_W'(1);
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= '0;
            pend_q  <= '0;
            led_q   <= 1'b0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pend_q  <= pend_d;
            led_q   <= (state_d == StOn);
            busy_q  <= (state_d != StIdle);
            ovf_q   <= ovf_d;
        end
    end

    assign led      = led_q;
    assign busy     = busy_q;
    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule
